// File: rtl/rack_jtag_chain_cfg.sv
// Loads the rack JTAG mux chain-enable register by bit-banging TTCK/TTDI
// with TCTRL_B held low; host JTAG is passed straight through when idle.
module rack_jtag_chain_cfg #(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NBITS-1:0] CFG_DATA,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [NBITS-1:0] CUR_CFG,
  input  logic             HOST_TCK,
  input  logic             HOST_TMS,
  input  logic             HOST_TDI,
  output logic             TTCK_O,
  output logic             TTMS_O,
  output logic             TTDI_O,
  output logic             TCTRL_B_O
);

  localparam int BW = $clog2(NBITS);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NBITS-1:0] cur_q, cur_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ttck_q, ttck_d;
  logic             ttms_q, ttms_d;
  logic             ttdi_q, ttdi_d;
  logic             tctrl_q, tctrl_d;
  logic             phase_end;

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    cur_d     = cur_q;
    done_d    = 1'b0;
    phase_end = (dcnt_q == 8'd0);

    unique case (state_q)
      S_IDLE: begin
        if (CFG_VALID && ready_q) begin
          state_d = S_SETUP;
          shreg_d = CFG_DATA;
          data_d  = CFG_DATA;
          bcnt_d  = LAST;
        end
      end
      S_SETUP: begin
        if (phase_end) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (phase_end) begin
          if (bcnt_q == '0) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_LOW;
            bcnt_d  = bcnt_q - BW'(1);
            shreg_d = shreg_q << 1;
          end
        end
      end
      S_LOW: begin
        if (phase_end) state_d = S_HIGH;
      end
      S_HOLD: begin
        if (phase_end) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (phase_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cur_d   = data_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE) dcnt_d = DIV_M1;
    else dcnt_d = phase_end ? DIV_M1 : dcnt_q - 8'd1;

    // Pins are decoded from the next state so they change with it.
    ttck_d  = 1'b0;
    ttms_d  = 1'b1;
    ttdi_d  = shreg_d[NBITS-1];
    tctrl_d = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        ttck_d  = HOST_TCK;
        ttms_d  = HOST_TMS;
        ttdi_d  = HOST_TDI;
        tctrl_d = 1'b1;
      end
      S_HIGH:    ttck_d  = 1'b1;
      S_RELEASE: tctrl_d = 1'b1;
      default: ;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      dcnt_q  <= DIV_M1;
      bcnt_q  <= LAST;
      shreg_q <= '0;
      data_q  <= '0;
      cur_q   <= NBITS'(1);
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ttck_q  <= HOST_TCK;
      ttms_q  <= HOST_TMS;
      ttdi_q  <= HOST_TDI;
      tctrl_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ttck_q  <= ttck_d;
      ttms_q  <= ttms_d;
      ttdi_q  <= ttdi_d;
      tctrl_q <= tctrl_d;
    end
  end

  assign CFG_READY = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CUR_CFG   = cur_q;
  assign TTCK_O    = ttck_q;
  assign TTMS_O    = ttms_q;
  assign TTDI_O    = ttdi_q;
  assign TCTRL_B_O = tctrl_q;

endmodule

// File: tb/tb_rack_jtag_chain_cfg.sv
// Bench for rack_jtag_chain_cfg: CLK_DIV=4 and CLK_DIV=1 lanes, each
// checked every cycle against a phase-arithmetic model and a mux model.
module tb_rack_jtag_chain_cfg;

  logic clk = 1'b0;
  logic rst;
  logic h_tck, h_tms, h_tdi;
  logic [7:0] cfg_data [2];
  logic cfg_valid [2];

  int vecs = 0;
  int errs = 0;

  logic rdy_w [2], bsy_w [2], dn_w [2];
  logic tck_w [2], tms_w [2], tdi_w [2], tctrl_w [2];
  logic [7:0] cur_w [2], mux_w [2], bits_w [2];
  int lat_w [2], rises_w [2];

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {tck, tms, tdi, tctrl_b} for cycle j after the accept edge
  function automatic logic [3:0] pins(int j, int d, logic [7:0] v);
    int p, b;
    logic ck, cb;
    p  = j / d;
    b  = (p >= 16) ? 0 : 7 - p / 2;
    ck = (p < 16) && (p % 2 == 1);
    cb = (p == 17);
    return {ck, 1'b1, v[b], cb};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ln
    localparam int D = (g == 0) ? 4 : 1;
    logic ready, busy, done, tck, tms, tdi, tctrl;
    logic [7:0] cur;

    rack_jtag_chain_cfg #(.CLK_DIV(D), .NBITS(8)) dut (
      .CLK(clk), .RST(rst),
      .CFG_DATA(cfg_data[g]), .CFG_VALID(cfg_valid[g]),
      .CFG_READY(ready), .BUSY(busy), .DONE(done), .CUR_CFG(cur),
      .HOST_TCK(h_tck), .HOST_TMS(h_tms), .HOST_TDI(h_tdi),
      .TTCK_O(tck), .TTMS_O(tms), .TTDI_O(tdi), .TCTRL_B_O(tctrl)
    );

    bit m_busy, m_ready, m_done, live, acc, rst_e;
    int j, ecnt, acc_at, last_rise, last_chg, rises, lat;
    logic [7:0] m_data, m_cur, mux, bits;
    logic [3:0] e;
    logic p_tck, p_tdi, p_tctrl;

    always @(posedge clk) begin
      logic [2:0] hv;
      hv = {h_tck, h_tms, h_tdi};
      acc = 1'b0;
      rst_e = rst;
      ecnt++;
      if (rst) begin
        live = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
        m_done = 1'b0; m_cur = 8'h01;
      end else if (m_busy) begin
        j++;
        m_done = 1'b0;
        if (j == 18 * D) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_cur = m_data; m_ready = 1'b1;
        end
      end else begin
        m_done = 1'b0;
        if (cfg_valid[g] && m_ready) begin
          acc = 1'b1; m_busy = 1'b1; j = 0;
          m_data = cfg_data[g]; m_ready = 1'b0;
        end else begin
          m_ready = 1'b1;
        end
      end
      e = m_busy ? pins(j, D, m_data) : {hv, 1'b1};
      #1;
      if (live) begin
        chk($sformatf("L%0d ready", g), ready, m_ready);
        chk($sformatf("L%0d busy", g), busy, m_busy);
        chk($sformatf("L%0d done", g), done, m_done);
        chk($sformatf("L%0d cur_cfg", g), cur, m_cur);
        chk($sformatf("L%0d ttck", g), tck, e[3]);
        chk($sformatf("L%0d ttms", g), tms, e[2]);
        chk($sformatf("L%0d ttdi", g), tdi, e[1]);
        chk($sformatf("L%0d tctrl_b", g), tctrl, e[0]);
        if (acc) begin
          rises = 0; bits = 8'h00; acc_at = ecnt;
        end
        if (tdi !== p_tdi) last_chg = ecnt;
        if (tck === 1'b1 && p_tck === 1'b0 && tctrl === 1'b0) begin
          if (rises > 0)
            chk($sformatf("L%0d ttck period", g), ecnt - last_rise, 2 * D);
          chk($sformatf("L%0d ttdi setup", g), (ecnt - last_chg) >= D, 1);
          mux = {mux[6:0], tdi};
          bits = {bits[6:0], tdi};
          rises++;
          last_rise = ecnt;
        end
        if (!rst_e && tctrl !== p_tctrl)
          chk($sformatf("L%0d tctrl edge ttck", g), tck, 0);
        if (done === 1'b1) lat = ecnt - acc_at;
      end
      p_tck = tck; p_tdi = tdi; p_tctrl = tctrl;
    end

    assign rdy_w[g] = ready;
    assign bsy_w[g] = busy;
    assign dn_w[g] = done;
    assign tck_w[g] = tck;
    assign tms_w[g] = tms;
    assign tdi_w[g] = tdi;
    assign tctrl_w[g] = tctrl;
    assign cur_w[g] = cur;
    assign mux_w[g] = mux;
    assign bits_w[g] = bits;
    assign lat_w[g] = lat;
    assign rises_w[g] = rises;
  end

  task automatic start(int g, logic [7:0] d);
    int n;
    @(negedge clk);
    cfg_data[g] = d;
    cfg_valid[g] = 1'b1;
    n = 0;
    while (!bsy_w[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept seen", bsy_w[g], 1);
    cfg_valid[g] = 1'b0;
  endtask

  task automatic wait_done(int g, bit tog);
    int n;
    n = 0;
    while (!dn_w[g] && n < 200) begin
      if (tog) {h_tck, h_tms, h_tdi} = 3'($urandom);
      @(negedge clk);
      n++;
    end
    chk("done seen", dn_w[g], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] pv;
    logic [7:0] mv;
    int n;
    rst = 1'b1;
    {h_tck, h_tms, h_tdi} = 3'b000;
    for (int i = 0; i < 2; i++) begin
      cfg_data[i] = 8'h00;
      cfg_valid[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset ready", rdy_w[0], 0);
    chk("reset busy", bsy_w[0], 0);
    chk("reset cur_cfg", cur_w[0], 8'h01);
    chk("reset tctrl_b", tctrl_w[0], 1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", rdy_w[0], 1);

    for (int i = 0; i < 5; i++) begin
      pv = 3'(i * 3 + 1);
      {h_tck, h_tms, h_tdi} = pv;
      @(negedge clk);
      chk("pass ttck", tck_w[0], pv[2]);
      chk("pass ttms", tms_w[0], pv[1]);
      chk("pass ttdi", tdi_w[0], pv[0]);
      chk("pass tctrl_b", tctrl_w[0], 1);
    end
    {h_tck, h_tms, h_tdi} = 3'b000;

    start(0, 8'hA5);
    wait_done(0, 1'b0);
    chk("A5 latency", lat_w[0], 72);
    chk("A5 ttdi bits", bits_w[0], 8'hA5);
    chk("A5 rises", rises_w[0], 8);
    chk("A5 mux", mux_w[0], 8'hA5);
    mv = mux_w[0];
    chk("A5 led", mv[7], 1);
    chk("A5 cur_cfg", cur_w[0], 8'hA5);

    start(0, 8'h03);
    wait_done(0, 1'b1);
    {h_tck, h_tms, h_tdi} = 3'b000;
    chk("03 rises", rises_w[0], 8);
    chk("03 mux", mux_w[0], 8'h03);

    @(negedge clk);
    cfg_data[0] = 8'h7F;
    cfg_valid[0] = 1'b1;
    n = 0;
    while (!bsy_w[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b first accept", bsy_w[0], 1);
    chk("b2b ready while busy", rdy_w[0], 0);
    cfg_data[0] = 8'h01;
    wait_done(0, 1'b0);
    chk("b2b ready on done", rdy_w[0], 1);
    chk("b2b first latency", lat_w[0], 72);
    chk("b2b first mux", mux_w[0], 8'h7F);
    @(negedge clk);
    chk("b2b second accept", bsy_w[0], 1);
    cfg_valid[0] = 1'b0;
    wait_done(0, 1'b0);
    chk("b2b second mux", mux_w[0], 8'h01);
    chk("b2b cur_cfg", cur_w[0], 8'h01);

    start(0, 8'h5A);
    n = 0;
    while (rises_w[0] < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort at bit 4", rises_w[0], 4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", bsy_w[0], 0);
    chk("abort tctrl_b", tctrl_w[0], 1);
    chk("abort cur_cfg", cur_w[0], 8'h01);
    chk("abort done", dn_w[0], 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort stays idle", bsy_w[0], 0);
    chk("abort cur kept", cur_w[0], 8'h01);

    start(1, 8'hFF);
    wait_done(1, 1'b0);
    chk("FF latency", lat_w[1], 18);
    chk("FF rises", rises_w[1], 8);
    chk("FF mux", mux_w[1], 8'hFF);
    chk("FF cur_cfg", cur_w[1], 8'hFF);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
